activation_stage: RTL

- Element-wise activation stage directly downstream of a fully-connected layer.
- Forward: consumes the layer's result vector and produces a leaky-ReLU output vector with optional positive saturation, one element per cycle.
- Stores a per-element derivative code.
- Backward: scales incoming gradients by the stored derivative and presents them to the layer's backward inputs.

---
 rtl/activation_stage_if.sv | 23 ++
 rtl/activation_stage.sv | 77 +++++++
 2 files changed

// File: rtl/activation_stage_if.sv
// activation_stage_if: handshake and vector bus between a fully-connected layer and its activation stage
interface activation_stage_if #(
  parameter int NUM_W = 16,
  parameter int ELEMS = 1
);
  logic start_f;
  logic start_b;
  logic ready_in;
  logic ready_out;
  logic done;
  logic [ELEMS-1:0][NUM_W-1:0] inputs_f;
  logic [ELEMS-1:0][NUM_W-1:0] inputs_b;
  logic [ELEMS-1:0][NUM_W-1:0] output_f;
  logic [ELEMS-1:0][NUM_W-1:0] output_b;
  modport master (
    output start_f, start_b, ready_in, inputs_f, inputs_b,
    input  output_f, output_b, ready_out, done
  );
  modport slave (
    input  start_f, start_b, ready_in, inputs_f, inputs_b,
    output output_f, output_b, ready_out, done
  );
endinterface

// File: rtl/activation_stage.sv
// activation_stage: leaky-ReLU forward pass with stored derivative codes used to scale backward gradients
module activation_stage #(
  parameter int INT_W = 8,
  parameter int FRAC_W = 8,
  parameter int NUM_W = INT_W + FRAC_W,
  parameter int ELEMS = 1,
  parameter int LEAK_SHIFT = 3,
  parameter int POS_LIMIT = 2 ** (NUM_W - 1) - 1
) (
  input logic clk,
  input logic reset,
  input logic enable,
  activation_stage_if.slave bus
);
  localparam int CW = ELEMS > 1 ? $clog2(ELEMS) : 1;
  localparam logic signed [NUM_W-1:0] LIM = NUM_W'(POS_LIMIT);
  typedef enum logic [1:0] {IDLE, WAIT, RUN_F, RUN_B} state_t;
  typedef enum logic [1:0] {LIN, LEAK, ZERO, SAT} code_t;
  state_t state, state_n;
  code_t deriv [ELEMS];
  code_t code, dc;
  logic dir_b, done, last, running;
  logic [CW-1:0] cnt;
  logic [ELEMS-1:0][NUM_W-1:0] out_f, out_b;
  logic signed [NUM_W-1:0] x, xs, y, g, gs, gb;
  assign bus.ready_out = state == IDLE;
  assign bus.done = done;
  assign bus.output_f = out_f;
  assign bus.output_b = out_b;
  assign last = cnt == CW'(ELEMS - 1);
  assign running = state == RUN_F || state == RUN_B;
  // current element: activation plus its derivative code, and the scaled gradient
  always_comb begin
    x = bus.inputs_f[cnt];
    g = bus.inputs_b[cnt];
    dc = deriv[cnt];
    xs = x >>> LEAK_SHIFT;
    gs = g >>> LEAK_SHIFT;
    code = x > LIM ? SAT : !x[NUM_W-1] ? LIN : LEAK_SHIFT == 0 ? ZERO : LEAK;
    y = code == SAT ? LIM : code == LIN ? x : code == LEAK ? xs : '0;
    gb = dc == LIN ? g : dc == LEAK ? gs : '0;
  end
  // next state: start in IDLE, wait for upstream data, then one edge per element
  always_comb begin
    state_n = state;
    if (state == IDLE && (bus.start_b || bus.start_f)) state_n = WAIT;
    else if (state == WAIT && bus.ready_in) state_n = dir_b ? RUN_B : RUN_F;
    else if (running && last) state_n = IDLE;
  end
  // state, counter, output vectors and derivative codes
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dir_b <= 1'b0;
      done <= 1'b0;
      out_f <= '0;
      out_b <= '0;
      for (int i = 0; i < ELEMS; i++) deriv[i] <= LIN;
    end else if (enable) begin
      state <= state_n;
      done <= running && last;
      if (state == IDLE) begin
        cnt <= '0;
        dir_b <= bus.start_b;
        if (bus.start_b) out_b <= '0;
        else if (bus.start_f) out_f <= '0;
      end
      if (running) cnt <= last ? '0 : cnt + 1'b1;
      if (state == RUN_F) begin
        out_f[cnt] <= y;
        deriv[cnt] <= code;
      end
      if (state == RUN_B) out_b[cnt] <= gb;
    end
  end
endmodule
